// File: rtl/hazard_pipe.sv
// Load-use hazard detection and ID/EX, EX/MEM, MEM/WB register tracking for EX-stage forwarding.
// Optional feature macro: LOAD_USE_STALL_EN enables stall/bubble insertion and the stall counter.
module hazard_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rt,
  input  logic             id_regw,
  input  logic             id_memread,
  input  logic             flush,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       mem_rd,
  output logic             mem_regw,
  output logic [4:0]       wb_rd,
  output logic             wb_regw,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic       ex_valid;
  logic       ex_regw;
  logic       ex_memread;
  logic [4:0] ex_rd;

`ifdef LOAD_USE_STALL_EN
  logic hz;

  // A load in EX whose result the ID instruction needs cannot be forwarded in time.
  assign hz = ex_valid & ex_memread & ex_regw & (ex_rd != 5'd0) & id_valid &
              ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  assign stall = hz & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  logic unused_ok;

  // Software supplies a delay slot after each load, so no interlock exists here.
  assign stall     = 1'b0;
  assign stall_cnt = '0;
  assign unused_ok = &{1'b0, ex_memread, id_uses_rt};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_regw    <= 1'b0;
      ex_memread <= 1'b0;
      ex_rs      <= 5'd0;
      ex_rt      <= 5'd0;
      ex_rd      <= 5'd0;
    end else if (flush || stall) begin
      ex_valid   <= 1'b0;
      ex_regw    <= 1'b0;
      ex_memread <= 1'b0;
      ex_rs      <= 5'd0;
      ex_rt      <= 5'd0;
      ex_rd      <= 5'd0;
    end else begin
      ex_valid   <= id_valid;
      ex_regw    <= id_regw & id_valid;
      ex_memread <= id_memread & id_valid;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
    end
  end

  // Older instructions always drain; only ID/EX is ever held or bubbled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd   <= 5'd0;
      mem_regw <= 1'b0;
      wb_rd    <= 5'd0;
      wb_regw  <= 1'b0;
    end else begin
      mem_rd   <= ex_rd;
      mem_regw <= ex_regw & ex_valid;
      wb_rd    <= mem_rd;
      wb_regw  <= mem_regw;
    end
  end

endmodule

// File: tb/tb_hazard_pipe.sv
// Scoreboard bench for hazard_pipe: directed vectors push expected outputs, a monitor pops and compares.
// Expectations follow the LOAD_USE_STALL_EN setting of the build.
module tb_hazard_pipe;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_uses_rt, id_regw, id_memread, flush;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic [4:0]    ex_rs, ex_rt, mem_rd, wb_rd;
  logic          mem_regw, wb_regw, stall;
  logic [CW-1:0] stall_cnt;

  typedef struct {
    string      name;
    logic       stall;
    logic [1:0] cnt;
    logic [4:0] exrs, exrt, memrd;
    logic       memrw;
    logic [4:0] wbrd;
    logic       wbrw;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  event sample_now;

`ifdef LOAD_USE_STALL_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  hazard_pipe #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_regw(id_regw), .id_memread(id_memread),
    .flush(flush), .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_rd(mem_rd), .mem_regw(mem_regw),
    .wb_rd(wb_rd), .wb_regw(wb_regw), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input string field, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s.%s actual=%0d required=%0d", name, field, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled on the falling edge or on demand.
  always begin
    exp_t e;
    @(negedge clk or sample_now);
    if (q.size() > 0) begin
      e = q.pop_front();
      checkOutput(e.name, "stall", stall, e.stall);
      checkOutput(e.name, "stall_cnt", stall_cnt, e.cnt);
      checkOutput(e.name, "ex_rs", ex_rs, e.exrs);
      checkOutput(e.name, "ex_rt", ex_rt, e.exrt);
      checkOutput(e.name, "mem_rd", mem_rd, e.memrd);
      checkOutput(e.name, "mem_regw", mem_regw, e.memrw);
      checkOutput(e.name, "wb_rd", wb_rd, e.wbrd);
      checkOutput(e.name, "wb_regw", wb_regw, e.wbrw);
    end
  end

  task automatic pushExp(input string name, input logic es, input logic [1:0] ec,
                         input logic [4:0] exs, ext, mrd, input logic mrw,
                         input logic [4:0] wrd, input logic wrw);
    exp_t e;
    e.name = name; e.stall = es; e.cnt = ec; e.exrs = exs; e.exrt = ext;
    e.memrd = mrd; e.memrw = mrw; e.wbrd = wrd; e.wbrw = wrw;
    q.push_back(e);
  endtask

  task automatic driveIn(input logic v, input logic [4:0] rs, rt, rd,
                         input logic ut, rw, mr, fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rt = ut; id_regw = rw; id_memread = mr; flush = fl;
  endtask

  // One cycle: drive inputs just after the rising edge, expect outputs seen before the next one.
  task automatic applyStimulus(input string name, input logic v, input logic [4:0] rs, rt, rd,
                               input logic ut, rw, mr, fl,
                               input logic es, input logic [1:0] ec,
                               input logic [4:0] exs, ext, mrd, input logic mrw,
                               input logic [4:0] wrd, input logic wrw);
    driveIn(v, rs, rt, rd, ut, rw, mr, fl);
    pushExp(name, es, ec, exs, ext, mrd, mrw, wrd, wrw);
    @(posedge clk);
    #1;
  endtask

  // Present a dependent add after a load, then pull reset low halfway through that cycle.
  task automatic resetMid(input logic [1:0] ec);
    driveIn(1, 8, 10, 9, 1, 1, 0, 0);
    pushExp("rst_pre", EN, ec, 29, 8, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    pushExp("rst_async", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    ->sample_now;
    #1;
    driveIn(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    driveIn(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef LOAD_USE_STALL_EN
    $display("[TB] stall-enabled build");
    // load r8 then dependent add
    applyStimulus("s1c1", 0,0,0,0,0,0,0,0,   0,0, 0,0, 0,0, 0,0);
    applyStimulus("s1c2", 1,29,8,8,0,1,1,0,  0,0, 0,0, 0,0, 0,0);
    applyStimulus("s1c3", 1,8,10,9,1,1,0,0,  1,0, 29,8, 0,0, 0,0);
    applyStimulus("s1c4", 1,8,10,9,1,1,0,0,  0,1, 0,0, 8,1, 0,0);
    applyStimulus("s1c5", 0,0,0,0,0,0,0,0,   0,1, 8,10, 0,0, 8,1);
    applyStimulus("s1c6", 0,0,0,0,0,0,0,0,   0,1, 0,0, 9,1, 0,0);
    applyStimulus("s1c7", 0,0,0,0,0,0,0,0,   0,1, 0,0, 0,0, 9,1);
    applyStimulus("s1c8", 0,0,0,0,0,0,0,0,   0,1, 0,0, 0,0, 0,0);
    // store reading r8 through rt
    applyStimulus("s2c1", 1,29,8,8,0,1,1,0,  0,1, 0,0, 0,0, 0,0);
    applyStimulus("s2c2", 1,29,8,0,1,0,0,0,  1,1, 29,8, 0,0, 0,0);
    applyStimulus("s2c3", 1,29,8,0,1,0,0,0,  0,2, 0,0, 8,1, 0,0);
    applyStimulus("s2c4", 0,0,0,0,0,0,0,0,   0,2, 29,8, 0,0, 8,1);
    applyStimulus("s2c5", 0,0,0,0,0,0,0,0,   0,2, 0,0, 0,0, 0,0);
    // rt matches but is not used as an operand
    applyStimulus("s2c6", 1,29,8,8,0,1,1,0,  0,2, 0,0, 0,0, 0,0);
    applyStimulus("s2c7", 1,29,8,12,0,1,0,0, 0,2, 29,8, 0,0, 0,0);
    applyStimulus("s2c8", 0,0,0,0,0,0,0,0,   0,2, 29,8, 8,1, 0,0);
    applyStimulus("s2c9", 0,0,0,0,0,0,0,0,   0,2, 0,0, 12,1, 8,1);
    applyStimulus("s2cA", 0,0,0,0,0,0,0,0,   0,2, 0,0, 0,0, 12,1);
    applyStimulus("s2cB", 0,0,0,0,0,0,0,0,   0,2, 0,0, 0,0, 0,0);
    // load r0 then reader of r0
    applyStimulus("s3c1", 1,29,0,0,0,1,1,0,  0,2, 0,0, 0,0, 0,0);
    applyStimulus("s3c2", 1,0,0,5,1,1,0,0,   0,2, 29,0, 0,0, 0,0);
    applyStimulus("s3c3", 0,0,0,0,0,0,0,0,   0,2, 0,0, 0,1, 0,0);
    applyStimulus("s3c4", 0,0,0,0,0,0,0,0,   0,2, 0,0, 5,1, 0,1);
    applyStimulus("s3c5", 0,0,0,0,0,0,0,0,   0,2, 0,0, 0,0, 5,1);
    applyStimulus("s3c6", 0,0,0,0,0,0,0,0,   0,2, 0,0, 0,0, 0,0);
    // flush together with a hazard
    applyStimulus("s4c1", 1,29,8,8,0,1,1,0,  0,2, 0,0, 0,0, 0,0);
    applyStimulus("s4c2", 1,8,10,9,1,1,0,1,  0,2, 29,8, 0,0, 0,0);
    applyStimulus("s4c3", 0,0,0,0,0,0,0,0,   0,2, 0,0, 8,1, 0,0);
    applyStimulus("s4c4", 0,0,0,0,0,0,0,0,   0,2, 0,0, 0,0, 8,1);
    applyStimulus("s4c5", 0,0,0,0,0,0,0,0,   0,2, 0,0, 0,0, 0,0);
    // back-to-back dependent loads, counter saturates
    applyStimulus("s5c1", 1,29,8,8,0,1,1,0,  0,2, 0,0, 0,0, 0,0);
    applyStimulus("s5c2", 1,8,9,9,0,1,1,0,   1,2, 29,8, 0,0, 0,0);
    applyStimulus("s5c3", 1,8,9,9,0,1,1,0,   0,3, 0,0, 8,1, 0,0);
    applyStimulus("s5c4", 1,9,9,10,1,1,0,0,  1,3, 8,9, 0,0, 8,1);
    applyStimulus("s5c5", 1,9,9,10,1,1,0,0,  0,3, 0,0, 9,1, 0,0);
    applyStimulus("s5c6", 0,0,0,0,0,0,0,0,   0,3, 9,9, 0,0, 9,1);
    applyStimulus("s5c7", 0,0,0,0,0,0,0,0,   0,3, 0,0, 10,1, 0,0);
    applyStimulus("s5c8", 0,0,0,0,0,0,0,0,   0,3, 0,0, 0,0, 10,1);
    applyStimulus("s5c9", 0,0,0,0,0,0,0,0,   0,3, 0,0, 0,0, 0,0);
    // reset in the middle of a stall
    applyStimulus("s6c1", 1,29,8,8,0,1,1,0,  0,3, 0,0, 0,0, 0,0);
    resetMid(3);
    applyStimulus("s6c2", 0,0,0,0,0,0,0,0,   0,0, 0,0, 0,0, 0,0);
    applyStimulus("s6c3", 0,0,0,0,0,0,0,0,   0,0, 0,0, 0,0, 0,0);
    applyStimulus("s6c4", 1,29,8,8,0,1,1,0,  0,0, 0,0, 0,0, 0,0);
    applyStimulus("s6c5", 1,8,10,9,1,1,0,0,  1,0, 29,8, 0,0, 0,0);
    applyStimulus("s6c6", 1,8,10,9,1,1,0,0,  0,1, 0,0, 8,1, 0,0);
    applyStimulus("s6c7", 0,0,0,0,0,0,0,0,   0,1, 8,10, 0,0, 8,1);
    applyStimulus("s6c8", 0,0,0,0,0,0,0,0,   0,1, 0,0, 9,1, 0,0);
    applyStimulus("s6c9", 0,0,0,0,0,0,0,0,   0,1, 0,0, 0,0, 9,1);
`else
    $display("[TB] stall-disabled build");
    // dependent add enters EX right behind the load
    applyStimulus("d1c1", 0,0,0,0,0,0,0,0,   0,0, 0,0, 0,0, 0,0);
    applyStimulus("d1c2", 1,29,8,8,0,1,1,0,  0,0, 0,0, 0,0, 0,0);
    applyStimulus("d1c3", 1,8,10,9,1,1,0,0,  0,0, 29,8, 0,0, 0,0);
    applyStimulus("d1c4", 0,0,0,0,0,0,0,0,   0,0, 8,10, 8,1, 0,0);
    applyStimulus("d1c5", 0,0,0,0,0,0,0,0,   0,0, 0,0, 9,1, 8,1);
    applyStimulus("d1c6", 0,0,0,0,0,0,0,0,   0,0, 0,0, 0,0, 9,1);
    applyStimulus("d1c7", 0,0,0,0,0,0,0,0,   0,0, 0,0, 0,0, 0,0);
    // flush still bubbles EX
    applyStimulus("d2c1", 1,29,8,8,0,1,1,0,  0,0, 0,0, 0,0, 0,0);
    applyStimulus("d2c2", 1,8,10,9,1,1,0,1,  0,0, 29,8, 0,0, 0,0);
    applyStimulus("d2c3", 0,0,0,0,0,0,0,0,   0,0, 0,0, 8,1, 0,0);
    applyStimulus("d2c4", 0,0,0,0,0,0,0,0,   0,0, 0,0, 0,0, 8,1);
    applyStimulus("d2c5", 0,0,0,0,0,0,0,0,   0,0, 0,0, 0,0, 0,0);
    // reset mid-stream
    applyStimulus("d3c1", 1,29,8,8,0,1,1,0,  0,0, 0,0, 0,0, 0,0);
    resetMid(0);
    applyStimulus("d3c2", 0,0,0,0,0,0,0,0,   0,0, 0,0, 0,0, 0,0);
    applyStimulus("d3c3", 0,0,0,0,0,0,0,0,   0,0, 0,0, 0,0, 0,0);
`endif
    applyStimulus("tail", 0,0,0,0,0,0,0,0,   0,EN, 0,0, 0,0, 0,0);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
